// File: rtl/fetch_unit.sv
// Instruction fetch stage plus IF/ID pipeline register: owns the PC, keeps one
// instruction-memory request in flight and hands fetched words to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        StallD_i,
  input  logic        FlushD_i,
  input  logic        PCSrcE_i,
  input  logic [31:0] PCTargetE_i,
  output logic [31:0] InstrD_o,
  output logic [31:0] PCD_o,
  output logic [31:0] PCPlus4D_o,
  output logic        ValidD_o
);

  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        drop_q, drop_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcp4_q, pcp4_d;

  logic        load;
  logic [31:0] load_instr;
  logic [31:0] load_pc;
  logic        kill;
  logic        can_load;
  logic [31:0] target;

  assign target   = PCTargetE_i & PC_MASK;
  // A flush retires the older instruction, so a same-cycle response may still land.
  assign can_load = !valid_q || !StallD_i || FlushD_i;

  always_comb begin
    // NOTE: every signal written here is given a default first so no latch is inferred.
    state_d     = state_q;
    pc_d        = pc_q;
    pc_out_d    = pc_out_q;
    drop_d      = drop_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    load        = 1'b0;
    load_instr  = imem_rsp_data_i;
    load_pc     = pc_out_q;
    kill        = 1'b0;

    if (PCSrcE_i) begin
      pc_d = target;
      kill = 1'b1;
      unique case (state_q)
        S_REQ: begin
          if (imem_req_ready_i) begin
            pc_out_d = pc_q;
            drop_d   = 1'b1;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid_i) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      kill = FlushD_i || (valid_q && !StallD_i);
      unique case (state_q)
        S_REQ: begin
          if (imem_req_ready_i) begin
            pc_out_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid_i) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else if (can_load) begin
              load    = 1'b1;
              state_d = S_REQ;
            end else begin
              buf_instr_d = imem_rsp_data_i;
              buf_pc_d    = pc_out_q;
              state_d     = S_HOLD;
            end
          end
        end
        default: begin
          load_instr = buf_instr_q;
          load_pc    = buf_pc_q;
          if (!StallD_i) begin
            load    = 1'b1;
            state_d = S_REQ;
          end
        end
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pcd_d   = load_pc;
      pcp4_d  = load_pc + 32'd4;
    end else if (kill) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    if (rst_i) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC & PC_MASK;
      pc_out_q    <= '0;
      drop_q      <= 1'b0;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= '0;
      valid_q     <= 1'b0;
      instr_q     <= NOP_INSTR;
      pcd_q       <= '0;
      pcp4_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_out_q    <= pc_out_d;
      drop_q      <= drop_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      pcd_q       <= pcd_d;
      pcp4_q      <= pcp4_d;
    end
  end

  assign imem_req_valid_o = (state_q == S_REQ) && !rst_i;
  assign imem_addr_o      = pc_q;
  assign InstrD_o         = instr_q;
  assign PCD_o            = pcd_q;
  assign PCPlus4D_o       = pcp4_q;
  assign ValidD_o         = valid_q;

endmodule
